load_store_unit: RTL
====================

# load_store_unit

Single-outstanding load/store sequencer between the processor datapath and port A of `Memory_Management`. It takes load, store and atomic swap requests over a valid/ready handshake and drives registered `enA`/`wenA`/`AddressA`/`WriteDataA` strobes. It captures `ReadDataA` after the memory's one-cycle synchronous read latency and returns the result over a valid/ready response channel. Port B (instruction fetch) is untouched by this block.

## Interface
- `ADDR_W`, default 15: word address width; matches `AddressA`.
- `DATA_W`, default 16: data width; matches `WriteDataA`/`ReadDataA`.
- `clk`  in  1  rising-edge clock, shared with `Memory_Management`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_op`  in  2  00 load, 01 store, 10 swap, 11 illegal.
- `req_addr`  in  ADDR_W  word address.
- `req_wdata`  in  DATA_W  store/swap data.
- `rsp_valid`  out  1  response present (load, swap, illegal only).
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_data`  out  DATA_W  loaded or pre-swap data; 0 on error.
- `rsp_err`  out  1  illegal op.
- `mem_enA`  out  1  to `enA`.
- `mem_wenA`  out  1  to `wenA`.
- `mem_AddressA`  out  ADDR_W  to `AddressA`.
- `mem_WriteDataA`  out  DATA_W  to `WriteDataA`.
- `mem_ReadDataA`  in  DATA_W  from `ReadDataA`; valid the cycle after `enA=1,wenA=0` is sampled.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, RESP. Reset state is IDLE.
- IDLE: `req_ready=1`. On `req_valid&&req_ready`, latch op/addr/wdata. Op 00/01/10 -> ISSUE. Op 11 -> RESP with `rsp_err=1`, `rsp_data=0`, no memory access.
- ISSUE: `mem_enA=1`, `mem_AddressA`=latched addr. For a store, `mem_wenA=1` and `mem_WriteDataA`=wdata, then -> IDLE with no response. For load/swap, `mem_wenA=0`, then -> WAIT.
- WAIT: no strobe. At the end of the cycle, capture `mem_ReadDataA` into `rsp_data`. Load -> RESP; swap -> WRITE.
- WRITE (swap only): `mem_enA=1`, `mem_wenA=1`, same address, `mem_WriteDataA`=wdata, then -> RESP.
- RESP: `rsp_valid=1`, and `rsp_data`/`rsp_err` held stable until `rsp_valid&&rsp_ready`, then -> IDLE. `req_ready=0` while waiting.
- All `mem_*` outputs and `rsp_*` outputs are registered; nothing is combinational from inputs.
- `mem_enA`/`mem_wenA` are 0 in IDLE, WAIT and RESP. `mem_AddressA`/`mem_WriteDataA` hold their last values.
- `rsp_err` is cleared on accept of any legal op.
- Address is used as-is: no wrap or range check. Addresses 0 and 2^ADDR_W-1 are both legal.

## Timing
- Reset (async, immediate): state IDLE; `req_ready=1`; `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`; `mem_enA=0`, `mem_wenA=0`, `mem_AddressA=0`, `mem_WriteDataA=0`.
- Reset mid-operation: the in-flight op is discarded. A write whose strobe was cleared before its sampling edge is not performed. No response is produced.
- Cycle numbering: request accepted at edge 0.
- Store: strobe during cycle 1, written at edge 1, `req_ready=1` in cycle 2. Throughput is 1 store per 2 cycles.
- Load: strobe in cycle 1, data captured at edge 2, `rsp_valid=1` from cycle 3.
- Swap: read in cycle 1, capture at edge 2, write in cycle 3, `rsp_valid=1` from cycle 4. The old value is returned.
- Illegal op: `rsp_valid=1` from cycle 1.
- With `rsp_ready` held high, the response lasts exactly one cycle and `req_ready=1` the next cycle.
- `req_*` inputs are ignored whenever `req_ready=0`.
- One op is outstanding at a time, so back-to-back dependent accesses observe program order (store then load returns the stored value).

## Test plan
- Reset: assert `rst_n=0` mid-swap in WAIT -> all outputs at reset values immediately; mem[0x0010] is unchanged afterwards.
- Store then load: store 0xBEEF @0x0123, then load @0x0123 -> `mem_enA`/`mem_wenA` pulse in cycle 1 only; `rsp_valid` 3 cycles after the load accept with `rsp_data=0xBEEF`, `rsp_err=0`.
- Swap: mem[0x7FFF]=0x1234, swap in 0xABCD -> `rsp_data=0x1234` at cycle 4; a following load @0x7FFF returns 0xABCD.
- Backpressure: hold `rsp_ready=0` for 5 cycles during a load response -> `rsp_valid`/`rsp_data` stable; `req_ready=0`; `mem_enA=0`; a new `req_valid` is ignored until the response is taken.
- Illegal op: `req_op=11` @0x0005 -> `rsp_valid` in cycle 1, `rsp_err=1`, `rsp_data=0`, no `mem_enA` pulse.
- Sweep: store addr j data j for j=1..2^15-2, then load each -> every `rsp_data` equals j.

Source files
------------

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and memory port A bundle for the load/store unit
interface load_store_unit_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              mem_enA;
    logic              mem_wenA;
    logic [ADDR_W-1:0] mem_AddressA;
    logic [DATA_W-1:0] mem_WriteDataA;
    logic [DATA_W-1:0] mem_ReadDataA;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_ReadDataA,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               mem_enA, mem_wenA, mem_AddressA, mem_WriteDataA
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_ReadDataA,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               mem_enA, mem_wenA, mem_AddressA, mem_WriteDataA
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store/swap sequencer for memory port A
module load_store_unit #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
) (
    input logic              i_clk,
    input logic              i_rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_SWAP  = 2'b10;

    state_t            r_state,     w_state;
    logic [1:0]        r_op,        w_op;
    logic [DATA_W-1:0] r_wdata,     w_wdata;
    logic              r_mem_en,    w_mem_en;
    logic              r_mem_wen,   w_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data,  w_rsp_data;
    logic              r_rsp_err,   w_rsp_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= OP_LOAD;
            r_wdata     <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_wdata     <= w_wdata;
            r_mem_en    <= w_mem_en;
            r_mem_wen   <= w_mem_wen;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= w_rsp_err;
        end
    end

    // Outputs are computed for the next state so every strobe and response is a flop.
    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_wdata     = r_wdata;
        w_mem_en    = 1'b0;
        w_mem_wen   = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_rsp_valid = 1'b0;
        w_rsp_data  = r_rsp_data;
        w_rsp_err   = r_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_op    = bus.req_op;
                    w_wdata = bus.req_wdata;
                    if (bus.req_op == 2'b11) begin
                        w_state     = S_RESP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_data  = '0;
                    end else begin
                        w_state    = S_ISSUE;
                        w_mem_en   = 1'b1;
                        w_mem_wen  = (bus.req_op == OP_STORE);
                        w_mem_addr = bus.req_addr;
                        w_rsp_err  = 1'b0;
                        if (bus.req_op == OP_STORE) begin
                            w_mem_wdata = bus.req_wdata;
                        end
                    end
                end
            end
            S_ISSUE: begin
                w_state = (r_op == OP_STORE) ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                w_rsp_data = bus.mem_ReadDataA;
                if (r_op == OP_SWAP) begin
                    w_state     = S_WRITE;
                    w_mem_en    = 1'b1;
                    w_mem_wen   = 1'b1;
                    w_mem_wdata = r_wdata;
                end else begin
                    w_state     = S_RESP;
                    w_rsp_valid = 1'b1;
                end
            end
            S_WRITE: begin
                w_state     = S_RESP;
                w_rsp_valid = 1'b1;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.req_ready      = (r_state == S_IDLE);
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.mem_enA        = r_mem_en;
    assign bus.mem_wenA       = r_mem_wen;
    assign bus.mem_AddressA   = r_mem_addr;
    assign bus.mem_WriteDataA = r_mem_wdata;
endmodule
